// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at launch and committed after 5 or 10 busy cycles.
// Optional macro MDU_DIVZERO_GUARD_EN: a divide by zero leaves HI/LO untouched instead of committing LO=all-ones, HI=A.
`timescale 1ns/1ps
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MD_start,
  input  logic [1:0]  MDop,
  input  logic        MD_mtHI,
  input  logic        MD_mtLO,
  input  logic        MD_Rsel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        MD_stall,
  output logic [31:0] MD_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [31:0] phi_reg, phi_next, plo_reg, plo_next;
`ifdef MDU_DIVZERO_GUARD_EN
  logic        hold_reg, hold_next;
`endif

  // Multiply: low 64 bits of the product of 64-bit extended operands
  // give the signed or unsigned 32x32 product depending on the extension.
  logic        is_unsigned, div_zero;
  logic [63:0] mul_a, mul_b, prod;
  assign is_unsigned = MDop[0];
  assign div_zero    = (B == 32'd0);
  assign mul_a = is_unsigned ? {32'd0, A} : {{32{A[31]}}, A};
  assign mul_b = is_unsigned ? {32'd0, B} : {{32{B[31]}}, B};
  assign prod  = mul_a * mul_b;

  // Divide on magnitudes, then restore signs; 0x80000000 / -1 falls out as 0x80000000.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign a_neg = ~is_unsigned & A[31];
  assign b_neg = ~is_unsigned & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;
  assign q_mag = div_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag = div_zero ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  logic [31:0] res_hi, res_lo;
  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (MDop[1]) begin
      if (div_zero) begin
        res_hi = A;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      phi_reg   <= 32'd0;
      plo_reg   <= 32'd0;
`ifdef MDU_DIVZERO_GUARD_EN
      hold_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      phi_reg   <= phi_next;
      plo_reg   <= plo_next;
`ifdef MDU_DIVZERO_GUARD_EN
      hold_reg  <= hold_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    phi_next   = phi_reg;
    plo_next   = plo_reg;
`ifdef MDU_DIVZERO_GUARD_EN
    hold_next  = hold_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (MD_start) begin
          phi_next   = res_hi;
          plo_next   = res_lo;
          cnt_next   = MDop[1] ? 4'd10 : 4'd5;
          state_next = RUN;
`ifdef MDU_DIVZERO_GUARD_EN
          hold_next  = MDop[1] & div_zero;
`endif
        end else if (MD_mtHI) begin
          hi_next = A;
        end else if (MD_mtLO) begin
          lo_next = A;
        end
      end
      RUN: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = IDLE;
`ifdef MDU_DIVZERO_GUARD_EN
          if (!hold_reg) begin
            hi_next = phi_reg;
            lo_next = plo_reg;
          end
`else
          hi_next = phi_reg;
          lo_next = plo_reg;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // MD_stall includes MD_start so a dependent instruction stalls in the launch cycle itself.
  always_comb begin
    busy     = (state_reg == RUN);
    MD_stall = busy | MD_start;
    MD_out   = MD_Rsel ? lo_reg : hi_reg;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: an arithmetic reference model checked every cycle, plus literal expectations per operation.
`timescale 1ns/1ps
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, MD_start, MD_mtHI, MD_mtLO, MD_Rsel;
  logic [1:0]  MDop;
  logic [31:0] A, B;
  logic        busy, MD_stall;
  logic [31:0] MD_out;

  int checks = 0;
  int fails  = 0;

`ifdef MDU_DIVZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .MD_start(MD_start), .MDop(MDop),
    .MD_mtHI(MD_mtHI), .MD_mtLO(MD_mtLO), .MD_Rsel(MD_Rsel),
    .A(A), .B(B), .busy(busy), .MD_stall(MD_stall), .MD_out(MD_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, result as {HI, LO}
  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    model_result = 64'd0;
    case (op)
      2'b00: model_result = 64'(sa * sb);
      2'b01: model_result = ua * ub;
      default: begin
        if (b == 32'd0) model_result = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          model_result = {r[31:0], q[31:0]};
        end else model_result = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  logic        m_keep;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0; m_left <= 0; m_keep <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && !m_keep) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (MD_start) begin
      {m_phi, m_plo} <= model_result(MDop, A, B);
      m_left <= MDop[1] ? 10 : 5;
      m_keep <= GUARD && MDop[1] && (B == 32'd0);
    end else if (MD_mtHI) m_hi <= A;
    else if (MD_mtLO) m_lo <= A;
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, busy}, {31'd0, m_left != 0});
    chk("cyc_stall", {31'd0, MD_stall}, {31'd0, (m_left != 0) || MD_start});
    chk("cyc_md_out", MD_out, MD_Rsel ? m_lo : m_hi);
  end

  task automatic read_hl(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    MD_Rsel = 1'b0; #1;
    chk({name, "_hi"}, MD_out, exp_hi);
    MD_Rsel = 1'b1; #1;
    chk({name, "_lo"}, MD_out, exp_lo);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit with_mt);
    @(posedge clk); #1;
    MD_start = 1'b1; MDop = op; A = a; B = b; MD_mtHI = with_mt;
    @(posedge clk); #1;
    MD_start = 1'b0; MD_mtHI = 1'b0;
  endtask

  task automatic wait_idle(inout int n);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic mt(input bit hi, input bit lo, input logic [31:0] a);
    @(posedge clk); #1;
    MD_mtHI = hi; MD_mtLO = lo; A = a;
    @(posedge clk); #1;
    MD_mtHI = 1'b0; MD_mtLO = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    start_op(op, a, b, 1'b0);
    wait_idle(n);
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    read_hl(name, exp_hi, exp_lo);
    $display("op %s A=%h B=%h busy=%0d -> HI=%h LO=%h", name, a, b, n, dut.hi_reg, dut.lo_reg);
  endtask

  initial begin
    int n;
    reset = 1'b1; MD_start = 0; MD_mtHI = 0; MD_mtLO = 0; MD_Rsel = 0; MDop = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    read_hl("reset", 32'd0, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // mult with simultaneous mtHI: start wins, mtHI is dropped
    n = 0;
    start_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle(n);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    read_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    $display("op mult -2*3 busy=%0d", n);

    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

    mt(1'b1, 1'b1, 32'hCAFE_F00D);
    read_hl("mt_prio", 32'hCAFE_F00D, 32'hFFFF_FFFE);
    $display("mt HI+LO A=cafef00d");
    mt(1'b1, 1'b0, 32'h1234_5678);
    read_hl("mthi", 32'h1234_5678, 32'hFFFF_FFFE);
    $display("mtHI A=12345678");
    mt(1'b0, 1'b1, 32'h0000_BEEF);
    read_hl("mtlo", 32'h1234_5678, 32'h0000_BEEF);
    $display("mtLO A=0000beef");

    // div -7/2 with start/mtLO requests held during the run; HI stays old until commit
    n = 0;
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    MD_mtLO = 1'b1; MD_start = 1'b1; MDop = 2'b01; A = 32'hDEAD_BEEF; B = 32'd7; MD_Rsel = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy) n++;
      chk("div_old_hi", MD_out, 32'h1234_5678);
    end
    @(posedge clk); #1;
    MD_mtLO = 1'b0; MD_start = 1'b0;
    wait_idle(n);
    chk("div_busy_cycles", 32'(n), 32'd10);
    read_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    $display("op div -7/2 busy=%0d", n);

    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    if (GUARD) run_op("divu_zero", 2'b11, 32'd5, 32'd0, 10, 32'h0000_0000, 32'h8000_0000);
    else       run_op("divu_zero", 2'b11, 32'd5, 32'd0, 10, 32'h0000_0005, 32'hFFFF_FFFF);

    // divu aborted by reset in busy cycle 4
    start_op(2'b11, 32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    read_hl("rst_mid", 32'd0, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1 read_hl("rst_no_commit", 32'd0, 32'd0);
    $display("divu 100/7 aborted by reset");

    run_op("mult_post_rst", 2'b00, 32'd7, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("divu", 2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
